// File: rtl/alu_exec.sv
// EX-stage execution unit: registered single-cycle ALU ops plus optional 32-step shift-add multu
// into HI/LO. Define ALU_MULTU_EN to build the multiplier, HI/LO and the MUL state.
module alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       ALUOperation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [5:0] OpAdd  = 6'b100000;
  localparam logic [5:0] OpSub  = 6'b100010;
  localparam logic [5:0] OpAnd  = 6'b100100;
  localparam logic [5:0] OpOr   = 6'b100101;
  localparam logic [5:0] OpSlt  = 6'b101010;
  localparam logic [5:0] OpSll  = 6'b000000;
  localparam logic [5:0] OpMfhi = 6'b010000;
  localparam logic [5:0] OpMflo = 6'b010010;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] hi_val, lo_val;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;

  // Combinational result of the single-cycle op currently on the inputs.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUOperation)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSll:   alu_res = b << shamt;
      OpMfhi:  alu_res = hi_val;
      OpMflo:  alu_res = lo_val;
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_MULTU_EN
  localparam logic [5:0]  OpMultu = 6'b011001;
  localparam int unsigned CntW    = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;

  assign hi_val = hi_q;
  assign lo_val = lo_q;
  assign busy   = (state_q == StMul);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    // Carry out of the add lands in bit WIDTH and is shifted back into the accumulator.
    mul_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (ALUOperation == OpMultu) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            done_d    = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = mul_sum[WIDTH:1];
        mplier_d = {mul_sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          hi_d      = acc_d;
          lo_d      = mplier_d;
          result_d  = mplier_d;
          zero_d    = (mplier_d == '0);
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  // No multiplier: multu falls into the unsupported-code path, HI/LO read as zero.
  assign hi_val = '0;
  assign lo_val = '0;
  assign busy   = 1'b0;

  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    if (start) begin
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      illegal_d = alu_ill;
      done_d    = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign done    = done_q;
  assign illegal = illegal_q;

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));
  a_illegal_zero:  assert property (@(posedge clk) disable iff (!rst_n)
                                    illegal |-> (result == '0));

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; multiply checks are built when ALU_MULTU_EN is defined.
module tb_alu_exec;

  localparam logic [5:0] OpAdd   = 6'b100000;
  localparam logic [5:0] OpSub   = 6'b100010;
  localparam logic [5:0] OpAnd   = 6'b100100;
  localparam logic [5:0] OpOr    = 6'b100101;
  localparam logic [5:0] OpSlt   = 6'b101010;
  localparam logic [5:0] OpSll   = 6'b000000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpMfhi  = 6'b010000;
  localparam logic [5:0] OpMflo  = 6'b010010;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  ALUOperation;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;

  int n_total;
  int n_bad;

  alu_exec #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ALUOperation (ALUOperation),
    .a            (a),
    .b            (b),
    .shamt        (shamt),
    .result       (result),
    .zero         (zero),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an op before an edge, return 1ns after the accepting edge with start low.
  task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh);
    @(negedge clk);
    start        = 1'b1;
    ALUOperation = op;
    a            = x;
    b            = y;
    shamt        = sh;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic single(input string tag, input logic [5:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] sh, input logic [31:0] exp);
    issue(op, x, y, sh);
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
    check_eq({tag, "_done"}, {31'b0, done}, 32'h1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

`ifdef ALU_MULTU_EN
  // Issue multu and wait (bounded) for done; returns the number of busy cycles seen.
  task automatic run_mul(input logic [31:0] x, input logic [31:0] y, output int busy_cyc,
                         output logic got_done);
    issue(OpMultu, x, y, 5'd0);
    busy_cyc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cyc++;
        step();
      end
    end
  endtask
`endif

  initial begin
    int   bc;
    logic gd;
    int   n_done;
    n_total      = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    ALUOperation = OpAdd;
    a            = '0;
    b            = '0;
    shamt        = '0;

    repeat (2) step();
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_zero", {31'b0, zero}, 32'h1);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_done", {31'b0, done}, 32'h0);
    check_eq("rst_illegal", {31'b0, illegal}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    single("rst_hi", OpMfhi, 32'h0, 32'h0, 5'd0, 32'h0);
    single("rst_lo", OpMflo, 32'h0, 32'h0, 5'd0, 32'h0);

    single("add_wrap", OpAdd, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
    step();
    check_eq("add_done_low", {31'b0, done}, 32'h0);
    check_eq("add_result_hold", result, 32'h0);
    single("sub_neg", OpSub, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
    single("and", OpAnd, 32'hF0F0_1234, 32'hFF00_FF0F, 5'd0, 32'hF000_1204);
    single("or", OpOr, 32'hF0F0_0000, 32'h0F00_00A5, 5'd0, 32'hFFF0_00A5);
    single("slt_neg", OpSlt, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1);
    single("slt_pos", OpSlt, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0);
    single("sll31", OpSll, 32'h0, 32'h1, 5'd31, 32'h8000_0000);
    single("sll4", OpSll, 32'hDEAD_BEEF, 32'h1234_5678, 5'd4, 32'h2345_6780);

    // Back-to-back: two ops accepted on consecutive edges.
    @(negedge clk);
    start = 1'b1; ALUOperation = OpAdd; a = 32'd1; b = 32'd2;
    @(negedge clk);
    check_eq("b2b_res0", result, 32'd3);
    check_eq("b2b_done0", {31'b0, done}, 32'h1);
    ALUOperation = OpSub; a = 32'd10; b = 32'd3;
    step();
    start = 1'b0;
    check_eq("b2b_res1", result, 32'd7);
    check_eq("b2b_done1", {31'b0, done}, 32'h1);

    issue(6'h3F, 32'h5, 32'h6, 5'd0);
    check_eq("ill_res", result, 32'h0);
    check_eq("ill_flag", {31'b0, illegal}, 32'h1);
    check_eq("ill_done", {31'b0, done}, 32'h1);
    single("ill_clear", OpAdd, 32'd4, 32'd4, 5'd0, 32'd8);
    check_eq("ill_clear_flag", {31'b0, illegal}, 32'h0);

`ifdef ALU_MULTU_EN
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, gd);
    check_eq("mul_done_seen", {31'b0, gd}, 32'h1);
    check_eq("mul_busy_cycles", bc, 32'd32);
    check_eq("mul_busy_drop", {31'b0, busy}, 32'h0);
    check_eq("mul_result_lo", result, 32'h1);
    single("mfhi_big", OpMfhi, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFE);
    single("mflo_big", OpMflo, 32'h0, 32'h0, 5'd0, 32'h1);
    issue(6'h3F, 32'h0, 32'h0, 5'd0);
    check_eq("ill_flag2", {31'b0, illegal}, 32'h1);
    single("mfhi_after_ill", OpMfhi, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFE);

    // start held with add for every busy cycle must be ignored.
    issue(OpMultu, 32'd3, 32'd4, 5'd0);
    n_done = 0;
    for (int i = 0; i < 32; i++) begin
      start = 1'b1; ALUOperation = OpAdd; a = 32'h100 + i; b = 32'h7;
      step();
      if (done) n_done++;
    end
    start = 1'b0;
    check_eq("busy_res", result, 32'd12);
    step();
    check_eq("busy_done_pulses", n_done, 32'd1);
    check_eq("busy_no_extra", {31'b0, done}, 32'h0);
    single("busy_hi", OpMfhi, 32'h0, 32'h0, 5'd0, 32'h0);
    single("busy_lo", OpMflo, 32'h0, 32'h0, 5'd0, 32'd12);

    // Reset at iteration 10 aborts the multiply and clears HI/LO.
    issue(OpMultu, 32'd7, 32'd9, 5'd0);
    repeat (9) step();
    check_eq("mid_busy_before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    step();
    check_eq("mid_busy", {31'b0, busy}, 32'h0);
    check_eq("mid_result", result, 32'h0);
    check_eq("mid_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    single("mid_lo", OpMflo, 32'h0, 32'h0, 5'd0, 32'h0);
    single("mid_hi", OpMfhi, 32'h0, 32'h0, 5'd0, 32'h0);
`else
    issue(OpMultu, 32'd3, 32'd4, 5'd0);
    check_eq("nomul_ill", {31'b0, illegal}, 32'h1);
    check_eq("nomul_res", result, 32'h0);
    check_eq("nomul_done", {31'b0, done}, 32'h1);
    check_eq("nomul_busy", {31'b0, busy}, 32'h0);
    single("nomul_hi", OpMfhi, 32'h0, 32'h0, 5'd0, 32'h0);
    single("nomul_lo", OpMflo, 32'h0, 32'h0, 5'd0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
